// File: rtl/multi_scanner_ctrl.sv
// Controller for a bank of cooperating scanners sharing one scan stream.
// One scanner fills at a time; when full it hands the stream to its round-robin
// successor (woken early to STANDBY). Full scanners drain at a fixed rate on flush.
module multi_scanner_ctrl #(
  parameter int unsigned  N_SCAN    = 2,
  parameter int unsigned  MEM_DEPTH = 100,
  parameter int unsigned  WAKE_LVL  = 80,
  parameter int unsigned  XFER_RATE = 10,
  localparam int unsigned MEM_W     = $clog2(MEM_DEPTH + 1),
  localparam int unsigned IDX_W     = (N_SCAN > 1) ? $clog2(N_SCAN) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      flush,
  output logic [3*N_SCAN-1:0]       state,
  output logic [MEM_W*N_SCAN-1:0]   mem_used,
  output logic [IDX_W-1:0]          active_idx,
  output logic                      rdy_flush,
  output logic                      overrun
);

  localparam logic [2:0] StLowPwr  = 3'd0;
  localparam logic [2:0] StStandby = 3'd1;
  localparam logic [2:0] StScan    = 3'd2;
  localparam logic [2:0] StIdle    = 3'd3;
  localparam logic [2:0] StXfer    = 3'd4;

  localparam logic [MEM_W-1:0] Depth   = MEM_W'(MEM_DEPTH);
  localparam logic [MEM_W-1:0] WakeLvl = MEM_W'(WAKE_LVL);
  localparam logic [MEM_W-1:0] Rate    = MEM_W'(XFER_RATE);

  logic [2:0]       r_state     [N_SCAN];
  logic [MEM_W-1:0] r_mem       [N_SCAN];
  logic [IDX_W-1:0] r_active;
  logic             r_overrun;

  logic [2:0]       w_state_nxt [N_SCAN];
  logic [MEM_W-1:0] w_mem_nxt   [N_SCAN];
  logic [IDX_W-1:0] w_active_nxt;
  logic             w_overrun_nxt;

  logic [IDX_W-1:0] w_succ;
  logic             w_scan_tick;
  logic             w_full;
  logic             w_any_idle;
  logic             w_any_xfer;
  logic [IDX_W-1:0] w_flush_idx;

  assign w_succ      = (r_active == IDX_W'(N_SCAN - 1)) ? '0 : r_active + IDX_W'(1);
  assign w_scan_tick = tick && (r_state[r_active] == StScan);
  // Active scanner is full now or becomes full on this edge.
  assign w_full      = (r_mem[r_active] == Depth) ||
                       (w_scan_tick && (r_mem[r_active] == Depth - MEM_W'(1)));

  // Find any IDLE / XFER scanner and the lowest-index IDLE one.
  always_comb begin
    w_any_idle  = 1'b0;
    w_any_xfer  = 1'b0;
    w_flush_idx = '0;
    for (int i = 0; i < int'(N_SCAN); i++) begin
      if (r_state[i] == StXfer) w_any_xfer = 1'b1;
      if ((r_state[i] == StIdle) && !w_any_idle) begin
        w_any_idle  = 1'b1;
        w_flush_idx = IDX_W'(i);
      end
    end
  end

  // Next-state: per-scanner fill/drain, then wake, handoff and flush overrides.
  always_comb begin
    w_state_nxt   = r_state;
    w_mem_nxt     = r_mem;
    w_active_nxt  = r_active;
    w_overrun_nxt = r_overrun;

    for (int i = 0; i < int'(N_SCAN); i++) begin
      case (r_state[i])
        StLowPwr, StStandby, StIdle: ;
        StScan: begin
          if (tick) begin
            if (r_mem[i] >= Depth - MEM_W'(1)) begin
              w_mem_nxt[i]   = Depth;
              w_state_nxt[i] = StIdle;
            end else begin
              w_mem_nxt[i] = r_mem[i] + MEM_W'(1);
            end
          end
        end
        StXfer: begin
          if (r_mem[i] <= Rate) begin
            w_mem_nxt[i]   = '0;
            w_state_nxt[i] = StLowPwr;
          end else begin
            w_mem_nxt[i] = r_mem[i] - Rate;
          end
        end
        default: w_state_nxt[i] = StLowPwr;
      endcase
    end

    if (tick && (r_state[r_active] != StScan)) w_overrun_nxt = 1'b1;

    if ((r_state[w_succ] == StLowPwr) && (r_mem[r_active] >= WakeLvl)) begin
      w_state_nxt[w_succ] = StStandby;
    end

    if (w_full && (r_state[w_succ] == StStandby)) begin
      w_state_nxt[w_succ] = StScan;
      w_active_nxt        = w_succ;
    end

    // rdy_flush is w_any_idle, so a scanner turning IDLE this edge is not eligible.
    if (flush && !w_any_xfer && w_any_idle) begin
      w_state_nxt[w_flush_idx] = StXfer;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_SCAN); i++) begin
        r_state[i] <= (i == 0) ? StScan : StLowPwr;
        r_mem[i]   <= '0;
      end
      r_active  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem     <= w_mem_nxt;
      r_active  <= w_active_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Pack per-scanner registers onto the flat output buses.
  always_comb begin
    state    = '0;
    mem_used = '0;
    for (int i = 0; i < int'(N_SCAN); i++) begin
      state[3*i +: 3]        = r_state[i];
      mem_used[MEM_W*i +: MEM_W] = r_mem[i];
    end
  end

  assign active_idx = r_active;
  assign rdy_flush  = w_any_idle;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_multi_scanner_ctrl.sv
// Bench for multi_scanner_ctrl: a default instance (A, N_SCAN=2) under directed
// stimulus and a second instance (B, N_SCAN=3, XFER_RATE=30) under random stimulus,
// both checked every cycle against a behavioural model.
module tb_multi_scanner_ctrl;

  localparam int DEPTH = 100;
  localparam int WAKE  = 80;
  localparam int MW    = 7;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic a_tick = 1'b0, a_flush = 1'b0, b_tick = 1'b0, b_flush = 1'b0;

  logic [5:0]  a_state;
  logic [13:0] a_mem;
  logic [0:0]  a_act;
  logic        a_rdy, a_ovr;
  logic [8:0]  b_state;
  logic [20:0] b_mem;
  logic [1:0]  b_act;
  logic        b_rdy, b_ovr;

  multi_scanner_ctrl u_a (
    .clk(clk), .reset(rst_a), .tick(a_tick), .flush(a_flush),
    .state(a_state), .mem_used(a_mem), .active_idx(a_act),
    .rdy_flush(a_rdy), .overrun(a_ovr)
  );

  multi_scanner_ctrl #(.N_SCAN(3), .XFER_RATE(30)) u_b (
    .clk(clk), .reset(rst_b), .tick(b_tick), .flush(b_flush),
    .state(b_state), .mem_used(b_mem), .active_idx(b_act),
    .rdy_flush(b_rdy), .overrun(b_ovr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: state codes 0 LOW_PWR, 1 STANDBY, 2 SCAN, 3 IDLE, 4 XFER.
  int ns_cfg[2] = '{2, 3};
  int xr_cfg[2] = '{10, 30};
  int m_st[2][8];
  int m_mem[2][8];
  int m_act[2];
  int m_ovr[2];
  int b_prev_act = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < 8; i++) begin
      m_st[k][i]  = (i == 0) ? 2 : 0;
      m_mem[k][i] = 0;
    end
    m_act[k] = 0;
    m_ovr[k] = 0;
  endtask

  task automatic model_step(input int k, input bit t, input bit f);
    int n, xr, a, s, lo;
    int nst[8];
    int nmem[8];
    bit full, any_x;
    n = ns_cfg[k];
    xr = xr_cfg[k];
    a = m_act[k];
    s = (a + 1) % n;
    for (int i = 0; i < 8; i++) begin
      nst[i]  = m_st[k][i];
      nmem[i] = m_mem[k][i];
    end
    full = (m_mem[k][a] == DEPTH) || (m_st[k][a] == 2 && t && m_mem[k][a] == DEPTH - 1);
    if (t) begin
      if (m_st[k][a] == 2) begin
        nmem[a] = m_mem[k][a] + 1;
        if (nmem[a] >= DEPTH) begin
          nmem[a] = DEPTH;
          nst[a]  = 3;
        end
      end else begin
        m_ovr[k] = 1;
      end
    end
    any_x = 0;
    for (int i = 0; i < n; i++) begin
      if (m_st[k][i] == 4) begin
        any_x   = 1;
        nmem[i] = m_mem[k][i] - xr;
        if (nmem[i] <= 0) begin
          nmem[i] = 0;
          nst[i]  = 0;
        end
      end
    end
    if (m_st[k][s] == 0 && m_mem[k][a] >= WAKE) nst[s] = 1;
    if (full && m_st[k][s] == 1) begin
      nst[s]   = 2;
      m_act[k] = s;
    end
    lo = -1;
    for (int i = n - 1; i >= 0; i--) if (m_st[k][i] == 3) lo = i;
    if (f && !any_x && lo >= 0) nst[lo] = 4;
    for (int i = 0; i < 8; i++) begin
      m_st[k][i]  = nst[i];
      m_mem[k][i] = nmem[i];
    end
  endtask

  task automatic check_dut(input int k, input logic [23:0] sv, input logic [55:0] mv,
                           input logic [2:0] act, input logic rdy, input logic ovr);
    bit any_idle;
    any_idle = 0;
    for (int i = 0; i < ns_cfg[k]; i++) begin
      cmp($sformatf("dut%0d_state%0d", k, i), 32'(sv[3*i +: 3]), m_st[k][i]);
      cmp($sformatf("dut%0d_mem%0d", k, i), 32'(mv[MW*i +: MW]), m_mem[k][i]);
      if (m_st[k][i] == 3) any_idle = 1;
    end
    cmp($sformatf("dut%0d_active", k), 32'(act), m_act[k]);
    cmp($sformatf("dut%0d_rdy_flush", k), 32'(rdy), 32'(any_idle));
    cmp($sformatf("dut%0d_overrun", k), 32'(ovr), m_ovr[k]);
  endtask

  task automatic check_all();
    int nx;
    check_dut(0, 24'(a_state), 56'(a_mem), 3'(a_act), a_rdy, a_ovr);
    check_dut(1, 24'(b_state), 56'(b_mem), 3'(b_act), b_rdy, b_ovr);
    nx = 0;
    for (int i = 0; i < 3; i++) if (b_state[3*i +: 3] == 3'd4) nx++;
    cmp("b_single_xfer", 32'(nx <= 1), 32'd1);
    if (32'(b_act) != 32'(b_prev_act)) begin
      cmp("b_rr_order", 32'(b_act), (b_prev_act + 1) % 3);
      b_prev_act = int'(b_act);
    end
  endtask

  // One clock cycle: A gets directed inputs, B random ones.
  task automatic cycle(input bit ta, input bit fa);
    bit tb_t, tb_f;
    tb_t    = ($urandom_range(0, 1) == 1);
    tb_f    = ($urandom_range(0, 7) == 0);
    a_tick  = ta;
    a_flush = fa;
    b_tick  = tb_t;
    b_flush = tb_f;
    @(posedge clk);
    model_step(0, ta, fa);
    model_step(1, tb_t, tb_f);
    #1;
    check_all();
  endtask

  initial begin
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #5;
    model_reset(0);
    model_reset(1);
    check_all();
    cmp("a_reset_state", 32'(a_state), 32'h02);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // A: continuous ticks, never flush, until stall and overrun.
    for (int e = 1; e <= 201; e++) begin
      cycle(1'b1, 1'b0);
      if (e == 80) cmp("a_e80_mem0", 32'(a_mem[6:0]), 80);
      if (e == 81) cmp("a_e81_state1_standby", 32'(a_state[5:3]), 1);
      if (e == 100) begin
        cmp("a_e100_state0_idle", 32'(a_state[2:0]), 3);
        cmp("a_e100_state1_scan", 32'(a_state[5:3]), 2);
        cmp("a_e100_active", 32'(a_act), 1);
        cmp("a_e100_rdy", 32'(a_rdy), 1);
        cmp("a_e100_ovr", 32'(a_ovr), 0);
      end
      if (e == 200) begin
        cmp("a_e200_state1_idle", 32'(a_state[5:3]), 3);
        cmp("a_e200_ovr", 32'(a_ovr), 0);
      end
      if (e == 201) begin
        cmp("a_e201_ovr", 32'(a_ovr), 1);
        cmp("a_e201_active", 32'(a_act), 1);
      end
    end

    // Flush the stalled pair: scanner 0 drains, wakes, takes over.
    cycle(1'b0, 1'b1);
    cmp("a_flush_xfer", 32'(a_state[2:0]), 4);
    cmp("a_flush_mem", 32'(a_mem[6:0]), 100);
    for (int j = 1; j <= 10; j++) begin
      cycle(1'b0, 1'b0);
      cmp($sformatf("a_drain_mem_%0d", j), 32'(a_mem[6:0]), 100 - 10 * j);
    end
    cmp("a_drain_lowpwr", 32'(a_state[2:0]), 0);
    cycle(1'b0, 1'b0);
    cmp("a_post_standby", 32'(a_state[2:0]), 1);
    cycle(1'b0, 1'b0);
    cmp("a_post_scan", 32'(a_state[2:0]), 2);
    cmp("a_post_active", 32'(a_act), 0);
    cmp("a_post_ovr_sticky", 32'(a_ovr), 1);

    // Put scanner 1 in XFER at mem 50, then async reset.
    cycle(1'b0, 1'b1);
    cmp("a_s1_xfer", 32'(a_state[5:3]), 4);
    for (int j = 0; j < 5; j++) cycle(1'b0, 1'b0);
    cmp("a_s1_mem50", 32'(a_mem[13:7]), 50);
    rst_a = 1'b1;
    #1;
    model_reset(0);
    check_all();
    cmp("a_async_state", 32'(a_state), 32'h02);
    cmp("a_async_mem", 32'(a_mem), 0);
    #1;
    rst_a = 1'b0;
    for (int j = 0; j < 3; j++) cycle(1'b1, 1'b0);
    cmp("a_refill_mem0", 32'(a_mem[6:0]), 3);

    // Random phase for both instances.
    for (int e = 0; e < 1500; e++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
